// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: configurable up-counter sequencer.
// A host loads terminal value, prescale divisor and mode through a
// valid/ready handshake, then starts the run. The block raises a one-cycle
// done pulse on terminal count and then either stops (one-shot) or reloads
// (periodic).
module counter_seq_ctrl #(
   parameter int COUNTER_WIDTH  = 4,
   parameter int PRESCALE_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [COUNTER_WIDTH-1:0]  cfg_limit,
   input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
   input  logic                      cfg_mode,
   input  logic                      start,
   input  logic                      stop,
   output logic [COUNTER_WIDTH-1:0]  count,
   output logic                      busy,
   output logic                      done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [COUNTER_WIDTH-1:0]  CNT_ONE   = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PRESCALE_WIDTH-1:0] PRESC_ONE = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]                state_q, state_d;
   logic [COUNTER_WIDTH-1:0]  count_q, count_d;
   logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
   logic [COUNTER_WIDTH-1:0]  limit_q, limit_d;
   logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
   logic                      mode_q, mode_d;
   logic                      done_q, done_d;
   logic                      tick;

   assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign count     = count_q;
   assign busy      = (state_q == ST_RUN);
   assign done      = done_q;
   assign tick      = (presc_q == prescale_q);

   // Next-state logic: handshake, start/stop control, prescaler and terminal count.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      presc_d    = presc_q;
      limit_d    = limit_q;
      prescale_d = prescale_q;
      mode_d     = mode_q;
      done_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cfg_valid) begin
               limit_d    = cfg_limit;
               prescale_d = cfg_prescale;
               mode_d     = cfg_mode;
               count_d    = '0;
               state_d    = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (start) begin
               state_d = ST_RUN;
               count_d = '0;
               presc_d = '0;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
               count_d = '0;
               presc_d = '0;
            end else if (tick) begin
               presc_d = '0;
               if (count_q == limit_q) begin
                  done_d = 1'b1;
                  if (mode_q) begin
                     count_d = '0;
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  count_d = count_q + CNT_ONE;
               end
            end else begin
               presc_d = presc_q + PRESC_ONE;
            end
         end
         ST_DONE: begin
            if (cfg_valid) begin
               limit_d    = cfg_limit;
               prescale_d = cfg_prescale;
               mode_d     = cfg_mode;
               count_d    = '0;
               state_d    = ST_ARMED;
            end else if (start) begin
               state_d = ST_RUN;
               count_d = '0;
               presc_d = '0;
            end else if (stop) begin
               state_d = ST_IDLE;
               count_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any run immediately with no done pulse.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         presc_q    <= '0;
         limit_q    <= '0;
         prescale_q <= '0;
         mode_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         presc_q    <= presc_d;
         limit_q    <= limit_d;
         prescale_q <= prescale_d;
         mode_q     <= mode_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: self-checking bench for counter_seq_ctrl.
// Every cycle the DUT is compared against an elapsed-time reference model;
// a table of hand-derived vectors and a few directed sequences cover the
// corner cases, followed by randomized traffic.
module tb_counter_seq_ctrl;

   localparam int CW = 4;
   localparam int PW = 4;

   logic          clk;
   logic          resetn;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [CW-1:0] cfg_limit;
   logic [PW-1:0] cfg_prescale;
   logic          cfg_mode;
   logic          start;
   logic          stop;
   logic [CW-1:0] count;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;

   counter_seq_ctrl #(.COUNTER_WIDTH(CW), .PRESCALE_WIDTH(PW)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_limit   (cfg_limit),
      .cfg_prescale(cfg_prescale),
      .cfg_mode    (cfg_mode),
      .start       (start),
      .stop        (stop),
      .count       (count),
      .busy        (busy),
      .done        (done)
   );

   // Free-running clock, 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the run is described by edges elapsed since start.
   typedef enum int {M_IDLE, M_ARMED, M_RUN, M_DONE} mstate_t;
   mstate_t m_state;
   int      m_L, m_P, m_mode, m_elapsed, m_count, m_done;

   typedef struct {
      logic          cv;
      logic [CW-1:0] lim;
      logic [PW-1:0] pre;
      logic          md;
      logic          st;
      logic          sp;
      int            e_count;
      int            e_busy;
      int            e_done;
      int            e_ready;
   } vec_t;
   vec_t tbl[$];

   task automatic modelReset();
      m_state = M_IDLE;
      m_L = 0; m_P = 0; m_mode = 0;
      m_elapsed = 0; m_count = 0; m_done = 0;
   endtask

   task automatic modelLatch();
      m_L = int'(cfg_limit);
      m_P = int'(cfg_prescale);
      m_mode = int'(cfg_mode);
      m_count = 0;
      m_state = M_ARMED;
   endtask

   task automatic modelBeginRun();
      m_state = M_RUN;
      m_elapsed = 0;
      m_count = 0;
   endtask

   task automatic modelStep();
      int period;
      period = (m_L + 1) * (m_P + 1);
      m_done = 0;
      case (m_state)
         M_IDLE: if (cfg_valid) modelLatch();
         M_ARMED: begin
            if (stop) m_state = M_IDLE;
            else if (start) modelBeginRun();
         end
         M_RUN: begin
            if (stop) begin
               m_state = M_IDLE;
               m_count = 0;
            end else begin
               m_elapsed++;
               if (m_elapsed % period == 0) begin
                  m_done = 1;
                  if (m_mode != 0) m_count = 0;
                  else begin
                     m_state = M_DONE;
                     m_count = m_L;
                  end
               end else begin
                  m_count = (m_elapsed % period) / (m_P + 1);
               end
            end
         end
         M_DONE: begin
            if (cfg_valid) modelLatch();
            else if (start) modelBeginRun();
            else if (stop) begin
               m_state = M_IDLE;
               m_count = 0;
            end
         end
         default: m_state = M_IDLE;
      endcase
   endtask

   task automatic checkExpect(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkExpect({tag, "_count"}, int'(count), m_count);
      checkExpect({tag, "_busy"}, int'(busy), (m_state == M_RUN) ? 1 : 0);
      checkExpect({tag, "_done"}, int'(done), m_done);
      checkExpect({tag, "_ready"}, int'(cfg_ready),
                  (m_state == M_IDLE || m_state == M_DONE) ? 1 : 0);
   endtask

   task automatic applyStimulus(input logic cv, input logic [CW-1:0] lim, input logic [PW-1:0] pre,
                                input logic md, input logic st, input logic sp, input string tag);
      cfg_valid = cv;
      cfg_limit = lim;
      cfg_prescale = pre;
      cfg_mode = md;
      start = st;
      stop = sp;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput(tag);
   endtask

   task automatic idleCycle(input string tag);
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, tag);
   endtask

   task automatic addVec(input logic cv, input logic [CW-1:0] lim, input logic [PW-1:0] pre,
                         input logic md, input logic st, input logic sp,
                         input int ec, input int eb, input int ed, input int er);
      vec_t v;
      v.cv = cv; v.lim = lim; v.pre = pre; v.md = md; v.st = st; v.sp = sp;
      v.e_count = ec; v.e_busy = eb; v.e_done = ed; v.e_ready = er;
      tbl.push_back(v);
   endtask

   // Hard time limit so the bench always terminates.
   initial begin
      #2ms;
      $display("[TB] FAIL watchdog got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence.
   initial begin
      int n;
      int found;
      int pulses;

      // One-shot L=3 P=0, then cfg+start together in DONE, then periodic L=2 P=1.
      addVec(1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
      addVec(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 0, 1, 0, 0);
      addVec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1, 1, 0, 0);
      addVec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2, 1, 0, 0);
      addVec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3, 1, 0, 0);
      addVec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3, 0, 1, 1);
      addVec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3, 0, 0, 1);
      addVec(1'b1, 4'd2, 4'd1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
      addVec(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 0, 1, 0, 0);
      addVec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 1, 0, 0);
      addVec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1, 1, 0, 0);
      addVec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1, 1, 0, 0);
      addVec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2, 1, 0, 0);
      addVec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2, 1, 0, 0);
      addVec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 1, 1, 0);
      addVec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 1, 0, 0);

      // Reset state.
      resetn = 1'b0;
      cfg_valid = 1'b0; cfg_limit = '0; cfg_prescale = '0; cfg_mode = 1'b0;
      start = 1'b0; stop = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset");
      @(negedge clk);
      resetn = 1'b1;

      // Table-driven vectors.
      foreach (tbl[i]) begin
         applyStimulus(tbl[i].cv, tbl[i].lim, tbl[i].pre, tbl[i].md, tbl[i].st, tbl[i].sp,
                       $sformatf("vec%0d", i));
         checkExpect($sformatf("vec%0d_tcount", i), int'(count), tbl[i].e_count);
         checkExpect($sformatf("vec%0d_tbusy", i), int'(busy), tbl[i].e_busy);
         checkExpect($sformatf("vec%0d_tdone", i), int'(done), tbl[i].e_done);
         checkExpect($sformatf("vec%0d_tready", i), int'(cfg_ready), tbl[i].e_ready);
      end

      // Two more periodic periods: done every 6 cycles, busy held.
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         idleCycle("periodic");
         if (done) pulses++;
         checkExpect("periodic_busy", int'(busy), 1);
      end
      checkExpect("periodic_pulses", pulses, 2);
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, "periodic_stop");

      // Stop mid-run when count==3.
      applyStimulus(1'b1, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, "stop3_cfg");
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, "stop3_start");
      for (int i = 0; i < 20 && int'(count) != 3; i++) idleCycle("stop3_wait");
      checkExpect("stop3_reach", int'(count), 3);
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, "stop3");
      checkExpect("stop3_count", int'(count), 0);
      checkExpect("stop3_busy", int'(busy), 0);
      checkExpect("stop3_done", int'(done), 0);

      // Stop on the terminal-tick cycle suppresses done.
      applyStimulus(1'b1, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, "stopT_cfg");
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, "stopT_start");
      for (int i = 0; i < 20 && int'(count) != 5; i++) idleCycle("stopT_wait");
      checkExpect("stopT_reach", int'(count), 5);
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, "stopT");
      checkExpect("stopT_done", int'(done), 0);
      checkExpect("stopT_busy", int'(busy), 0);
      idleCycle("stopT_after");
      checkExpect("stopT_done2", int'(done), 0);

      // Configuration offered during RUN is ignored.
      applyStimulus(1'b1, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, "runcfg_cfg");
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, "runcfg_start");
      for (int i = 0; i < 3; i++) begin
         checkExpect("runcfg_ready", int'(cfg_ready), 0);
         applyStimulus(1'b1, 4'd7, 4'd3, 1'b1, 1'b0, 1'b0, "runcfg");
      end
      checkExpect("runcfg_done", int'(done), 1);
      checkExpect("runcfg_count", int'(count), 2);
      idleCycle("runcfg_hold");
      // Restart from DONE with the stored configuration.
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, "restart_start");
      repeat (3) idleCycle("restart");
      checkExpect("restart_done", int'(done), 1);
      checkExpect("restart_count", int'(count), 2);

      // Asynchronous reset between edges mid-run.
      applyStimulus(1'b1, 4'd9, 4'd1, 1'b0, 1'b0, 1'b0, "arst_cfg");
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, "arst_start");
      repeat (5) idleCycle("arst_run");
      #2;
      resetn = 1'b0;
      #1;
      modelReset();
      checkExpect("arst_count", int'(count), 0);
      checkExpect("arst_busy", int'(busy), 0);
      checkExpect("arst_done", int'(done), 0);
      checkExpect("arst_ready", int'(cfg_ready), 1);
      @(negedge clk);
      resetn = 1'b1;
      idleCycle("arst_after");

      // L=0 P=0 periodic: done stays high.
      applyStimulus(1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, "l0_cfg");
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, "l0_start");
      for (int i = 0; i < 10; i++) begin
         idleCycle("l0");
         checkExpect("l0_done", int'(done), 1);
         checkExpect("l0_count", int'(count), 0);
      end
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, "l0_stop");

      // L=15 P=15 one-shot: done 256 edges after the start edge.
      applyStimulus(1'b1, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, "max_cfg");
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, "max_start");
      found = 0;
      n = 0;
      while (n < 400 && found == 0) begin
         n++;
         idleCycle("max");
         if (done) found = n;
      end
      checkExpect("max_latency", found, 256);
      checkExpect("max_count", int'(count), 15);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 1500; i++) begin
         logic cv, st, sp, md;
         logic [CW-1:0] lim;
         logic [PW-1:0] pre;
         cv = ($urandom_range(0, 9) < 3);
         st = ($urandom_range(0, 9) < 3);
         sp = ($urandom_range(0, 29) == 0);
         md = 1'(($urandom) & 1);
         lim = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(0, 15)) : CW'($urandom_range(0, 4));
         pre = PW'($urandom_range(0, 2));
         applyStimulus(cv, lim, pre, md, st, sp, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
